pipe_stage_reg: RTL and testbench

Parametrised pipeline register chain with valid/ready handshake, per-stage skid buffering and synchronous flush. It is the successor to the plain width-parametrised enable-less register used between CPU pipeline stages. It carries a WIDTH-bit payload through DEPTH stages at full throughput, absorbs back-pressure without combinational ready paths, and can be killed on branch or exception.

---
 rtl/pipe_pkg.sv | 8 +
 rtl/skid_stage.sv | 45 ++++
 rtl/pipe_stage_reg.sv | 43 ++++
 tb/tb_pipe_stage_reg.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared defaults for the pipeline register chain
package pipe_pkg;
  localparam int DEF_WIDTH = 32;
  localparam logic [DEF_WIDTH-1:0] NOP_INSN = 32'h0000_0013;
  function automatic int cnt_w(input int depth);
    return $clog2(2 * depth + 1);
  endfunction
endpackage

// File: rtl/skid_stage.sv
// skid_stage: one valid/ready register stage with a skid entry so ready is registered
module skid_stage
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  logic m_vld_q, m_vld_d, s_vld_q, s_vld_d;
  logic [WIDTH-1:0] m_dat_q, m_dat_d, s_dat_q, s_dat_d;
  logic acc, ld;
  assign in_ready  = !s_vld_q;
  assign out_valid = m_vld_q;
  assign out_data  = m_dat_q;
  always_comb begin
    acc     = in_valid && !s_vld_q;
    ld      = !m_vld_q || out_ready;
    m_vld_d = !flush && (ld ? (s_vld_q || acc) : m_vld_q);
    s_vld_d = !flush && !ld && (s_vld_q || acc);
    m_dat_d = flush ? RESET_VAL : (ld && s_vld_q) ? s_dat_q : (ld && acc) ? in_data : m_dat_q;
    s_dat_d = flush ? RESET_VAL : (!ld && acc) ? in_data : s_dat_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_vld_q <= 1'b0;
      s_vld_q <= 1'b0;
      m_dat_q <= RESET_VAL;
      s_dat_q <= RESET_VAL;
    end else begin
      m_vld_q <= m_vld_d;
      s_vld_q <= s_vld_d;
      m_dat_q <= m_dat_d;
      s_dat_q <= s_dat_d;
    end
  end
endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: DEPTH-stage valid/ready register chain with skid buffering, flush and occupancy count
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WIDTH-1:0]          in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WIDTH-1:0]          out_data,
  output logic [cnt_w(DEPTH)-1:0]   count
);
  localparam int CW = cnt_w(DEPTH);
  logic [DEPTH:0] v, r;
  logic [WIDTH-1:0] d [DEPTH+1];
  logic [CW-1:0] cnt_q, cnt_d;
  assign v[0]      = in_valid;
  assign d[0]      = in_data;
  assign in_ready  = r[0];
  assign r[DEPTH]  = out_ready;
  assign out_valid = v[DEPTH];
  assign out_data  = d[DEPTH];
  assign count     = cnt_q;
  for (genvar i = 0; i < DEPTH; i++) begin : g_st
    skid_stage #(.WIDTH(WIDTH), .RESET_VAL(RESET_VAL)) u_st (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(v[i]), .in_ready(r[i]), .in_data(d[i]),
      .out_valid(v[i+1]), .out_ready(r[i+1]), .out_data(d[i+1])
    );
  end
  always_comb cnt_d = flush ? '0 : cnt_q + CW'(in_valid && in_ready) - CW'(out_valid && out_ready);
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: chain-of-2-deep-FIFOs model plus order scoreboard, with directed literal checks
module tb_pipe_stage_reg;
  localparam int W = 8, D = 2;
  localparam logic [W-1:0] RV = 8'hA5;
  localparam int CW = $clog2(2 * D + 1);
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [W-1:0] in_data = '0;
  logic in_ready, out_valid;
  logic [W-1:0] out_data;
  logic [CW-1:0] count;
  int nvec = 0, nerr = 0, n;
  bit en = 0;
  logic [W-1:0] st [D][2];
  int occ [D];
  logic [W-1:0] sb [$];
  logic [W-1:0] log_q [$];
  always #5 clk = ~clk;
  pipe_stage_reg #(.WIDTH(W), .DEPTH(D), .RESET_VAL(RV)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic cyc(input logic v, input logic [W-1:0] dd, input logic r, input logic f);
    in_valid = v; in_data = dd; out_ready = r; flush = f;
    @(posedge clk); #1;
  endtask
  // each stage is an abstract queue of up to two entries; items hop forward when the next has room
  always @(posedge clk or negedge rst) begin : model
    bit ov [D], ir [D], push [D], pop [D];
    logic [W-1:0] pd [D];
    if (!rst) begin
      for (int k = 0; k < D; k++) occ[k] = 0;
      sb.delete();
    end else begin
      for (int k = 0; k < D; k++) begin
        ov[k] = occ[k] > 0;
        ir[k] = occ[k] < 2;
      end
      for (int k = 0; k < D; k++) begin
        if (k == 0) begin
          push[k] = in_valid && ir[0];
          pd[k] = in_data;
        end else begin
          push[k] = ov[k-1] && ir[k];
          pd[k] = st[k-1][0];
        end
      end
      for (int k = 0; k < D; k++) pop[k] = (k == D - 1) ? (ov[k] && out_ready) : push[k+1];
      for (int k = 0; k < D; k++) begin
        if (pop[k]) begin st[k][0] = st[k][1]; occ[k]--; end
        if (push[k]) begin st[k][occ[k]] = pd[k]; occ[k]++; end
        if (flush) occ[k] = 0;
      end
    end
  end
  always @(negedge clk) begin : compare
    int tot;
    if (en && rst) begin
      tot = 0;
      for (int k = 0; k < D; k++) tot += occ[k];
      chk("out_valid", out_valid, occ[D-1] > 0);
      chk("in_ready", in_ready, occ[0] < 2);
      chk("count", count, tot);
      if (out_valid) chk("out_data", out_data, st[D-1][0]);
      if (out_valid && out_ready) begin
        log_q.push_back(out_data);
        if (sb.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL order: got %0h expected nothing pending", out_data);
        end else chk("order", out_data, sb.pop_front());
      end
      if (in_valid && in_ready) sb.push_back(in_data);
      if (flush) sb.delete();
    end
  end
  initial begin
    #3 rst = 0; #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, RV);
    chk("rst_count", count, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk); #1; rst = 1; en = 1;
    log_q.delete();
    for (int i = 0; i < 16; i++) begin
      cyc(1, W'(i + 1), 1, 0);
      if (i == 0) chk("lat_e1_valid", out_valid, 0);
      if (i == 1) begin
        chk("lat_e2_valid", out_valid, 1);
        chk("lat_e2_data", out_data, 1);
      end
    end
    repeat (4) cyc(0, '0, 1, 0);
    chk("stream_n", log_q.size(), 16);
    if (log_q.size() == 16) for (int i = 0; i < 16; i++) chk("stream_item", log_q[i], i + 1);
    chk("stream_count", count, 0);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (in_ready) n++;
      cyc(1, W'(8'h20 + i), 0, 0);
    end
    chk("bp_accepts", n, 4);
    chk("bp_count", count, 4);
    chk("bp_in_ready", in_ready, 0);
    log_q.delete();
    repeat (6) cyc(0, '0, 1, 0);
    chk("bp_n", log_q.size(), 4);
    if (log_q.size() == 4) for (int i = 0; i < 4; i++) chk("bp_item", log_q[i], 8'h20 + i);
    for (int i = 0; i < 3; i++) cyc(1, W'(8'h30 + i), 0, 0);
    chk("fl_pre_count", count, 3);
    log_q.delete();
    cyc(1, 8'h77, 0, 1);
    chk("fl_count", count, 0);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    repeat (5) cyc(0, '0, 1, 0);
    chk("fl_nothing_out", log_q.size(), 0);
    for (int i = 0; i < 10000; i++)
      cyc(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0);
    repeat (6) cyc(0, '0, 1, 0);
    chk("rand_drained", count, 0);
    for (int i = 0; i < 6; i++) cyc(1, W'(8'h50 + i), 0, 0);
    chk("ar_pre_count", count, 4);
    #1 rst = 0; #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_out_data", out_data, RV);
    chk("ar_count", count, 0);
    chk("ar_in_ready", in_ready, 1);
    #1 rst = 1;
    log_q.delete();
    cyc(1, 8'h61, 1, 0);
    cyc(1, 8'h62, 1, 0);
    repeat (4) cyc(0, '0, 1, 0);
    chk("ar_resume_n", log_q.size(), 2);
    if (log_q.size() == 2) begin
      chk("ar_resume_0", log_q[0], 8'h61);
      chk("ar_resume_1", log_q[1], 8'h62);
    end
    chk("ar_resume_count", count, 0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
